// File: rtl/delivery_game_uc.sv
// Control unit for the delivery game: clears the datapath at start, paces ultrasonic
// velocity measurements with a timeout, gates map movement and detects lose/win/pause.
module delivery_game_uc #(
    parameter int unsigned MEAS_PERIOD = 25_000_000,
    parameter int unsigned TIMEOUT     = 2_500_000,
    parameter logic [2:0]  WIN_SCORE   = 3'd7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       pausar,
    input  logic       game_over,
    input  logic [2:0] pontuacao,
    input  logic       velocity_ready,
    output logic       count_map,
    output logic       get_velocity,
    output logic       zera_fd,
    output logic       fim_jogo,
    output logic       vitoria,
    output logic       sensor_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CLEAR     = 4'd1,
        MEASURE   = 4'd2,
        WAIT_MEAS = 4'd3,
        PLAY      = 4'd4,
        PAUSED    = 4'd5,
        LOSE      = 4'd6,
        WIN       = 4'd7
    } state_t;

    localparam logic [31:0] PER_LAST = 32'(MEAS_PERIOD - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] per_q, per_d, to_q, to_d;
    logic        first_q, first_d, tout_q, tout_d;
    logic        ini_q, pau_q;
    logic        ini_ev, pau_ev, win_hit;
    logic        count_map_q, get_velocity_q, zera_fd_q, fim_jogo_q, vitoria_q;
    logic [3:0]  db_estado_q;

    assign ini_ev  = iniciar & ~ini_q;
    assign pau_ev  = pausar & ~pau_q;
    assign win_hit = (pontuacao == WIN_SCORE);

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        to_d    = to_q;
        first_d = first_q;
        tout_d  = tout_q;
        case (state_q)
            IDLE: if (ini_ev) state_d = CLEAR;
            CLEAR: begin
                per_d   = '0;
                to_d    = '0;
                tout_d  = 1'b0;
                first_d = 1'b0;
                state_d = MEASURE;
            end
            MEASURE: begin
                to_d = '0;
                if (game_over && first_q) state_d = LOSE;
                else if (win_hit)         state_d = WIN;
                else                      state_d = WAIT_MEAS;
            end
            WAIT_MEAS: begin
                to_d = to_q + 32'd1;
                // ready wins over a simultaneous timeout, so the flag stays clear
                if (game_over && first_q) state_d = LOSE;
                else if (win_hit)         state_d = WIN;
                else if (velocity_ready)  state_d = PLAY;
                else if (to_q == TO_LAST) begin
                    state_d = PLAY;
                    tout_d  = 1'b1;
                end
                if (state_d != WAIT_MEAS) first_d = 1'b1;
            end
            PLAY: begin
                per_d = (per_q == PER_LAST) ? '0 : per_q + 32'd1;
                if (game_over)              state_d = LOSE;
                else if (win_hit)           state_d = WIN;
                else if (pau_ev)            state_d = PAUSED;
                else if (per_q == PER_LAST) state_d = MEASURE;
            end
            PAUSED: if (pau_ev) state_d = PLAY;
            LOSE, WIN: if (ini_ev) state_d = CLEAR;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with db_estado.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            per_q          <= '0;
            to_q           <= '0;
            first_q        <= 1'b0;
            tout_q         <= 1'b0;
            ini_q          <= 1'b0;
            pau_q          <= 1'b0;
            count_map_q    <= 1'b0;
            get_velocity_q <= 1'b0;
            zera_fd_q      <= 1'b0;
            fim_jogo_q     <= 1'b0;
            vitoria_q      <= 1'b0;
            db_estado_q    <= 4'd0;
        end else begin
            state_q        <= state_d;
            per_q          <= per_d;
            to_q           <= to_d;
            first_q        <= first_d;
            tout_q         <= tout_d;
            ini_q          <= iniciar;
            pau_q          <= pausar;
            count_map_q    <= (state_d == PLAY) ||
                              (((state_d == MEASURE) || (state_d == WAIT_MEAS)) && first_d);
            get_velocity_q <= (state_d == MEASURE);
            zera_fd_q      <= (state_d == CLEAR);
            fim_jogo_q     <= (state_d == LOSE);
            vitoria_q      <= (state_d == WIN);
            db_estado_q    <= state_d;
        end
    end

    assign count_map      = count_map_q;
    assign get_velocity   = get_velocity_q;
    assign zera_fd        = zera_fd_q;
    assign fim_jogo       = fim_jogo_q;
    assign vitoria        = vitoria_q;
    assign sensor_timeout = tout_q;
    assign db_estado      = db_estado_q;

endmodule
